map_server: RTL and testbench

//  Owns the tile-wall map of the tank arena. Answers VGA pixel-tile requests
//  (request_x/request_y -> is_wall) and tank/shell collision queries.

---
 rtl/map_server_if.sv | 32 +++
 rtl/map_server.sv | 111 +++++++++++
 tb/tb_map_server.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/map_server_if.sv
// Bus bundle between the map server and its clients: VGA tile lookup,
// collision query, wall-update writes and load control.
interface map_server_if #(
  parameter int COORD_W = 6
);
  logic               i_reload;
  logic               i_busy;
  logic [COORD_W-1:0] i_x_pos;
  logic [COORD_W-1:0] i_y_pos;
  logic               o_is_map;
  logic [COORD_W-1:0] i_q_x;
  logic [COORD_W-1:0] i_q_y;
  logic               o_q_wall;
  logic               i_wr_valid;
  logic [COORD_W-1:0] i_wr_x;
  logic [COORD_W-1:0] i_wr_y;
  logic               i_wr_wall;
  logic               o_wr_ready;
  logic               o_init_done;

  modport master (
    output i_reload, i_busy, i_x_pos, i_y_pos, i_q_x, i_q_y,
           i_wr_valid, i_wr_x, i_wr_y, i_wr_wall,
    input  o_is_map, o_q_wall, o_wr_ready, o_init_done
  );

  modport slave (
    input  i_reload, i_busy, i_x_pos, i_y_pos, i_q_x, i_q_y,
           i_wr_valid, i_wr_x, i_wr_y, i_wr_wall,
    output o_is_map, o_q_wall, o_wr_ready, o_init_done
  );
endinterface

// File: rtl/map_server.sv
// Tile-wall map of the tank arena: default-map loader, two registered read
// ports (VGA and collision) and a single write port gated by VGA activity.
module map_server #(
  parameter int MAP_W   = 40,
  parameter int MAP_H   = 30,
  parameter int COORD_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  map_server_if.slave  bus
);
  localparam int CELLS = MAP_W * MAP_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(MAP_H - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_reg;
  logic [IDX_W-1:0]   cnt_reg;
  logic [COORD_W-1:0] init_x_reg;
  logic [COORD_W-1:0] init_y_reg;
  logic [CELLS-1:0]   map_reg;
  logic               is_map_reg;
  logic               q_wall_reg;
  logic               init_done_reg;

  logic               is_map_next;
  logic               q_wall_next;
  logic               default_bit;
  logic               wr_fire;

  function automatic logic in_map(input logic [COORD_W-1:0] x,
                                  input logic [COORD_W-1:0] y);
    return (32'(x) < 32'(MAP_W)) && (32'(y) < 32'(MAP_H));
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    logic [31:0] t;
    t = 32'(y) * 32'(MAP_W) + 32'(x);
    return t[IDX_W-1:0];
  endfunction

  // Loader walks x/y alongside the linear counter to avoid a divider.
  always_comb begin
    default_bit = (init_x_reg == '0) || (init_x_reg == X_LAST) ||
                  (init_y_reg == '0) || (init_y_reg == Y_LAST) ||
                  (((32'(init_x_reg) % 32'd8) == 32'd4) &&
                   ((32'(init_y_reg) % 32'd6) == 32'd3));
  end

  // Off-map coordinates read as wall so tanks cannot leave the arena.
  always_comb begin
    is_map_next = 1'b0;
    q_wall_next = 1'b0;
    if (state_reg == ST_RUN) begin
      is_map_next = in_map(bus.i_x_pos, bus.i_y_pos) ?
                    map_reg[cell_idx(bus.i_x_pos, bus.i_y_pos)] : 1'b1;
      q_wall_next = in_map(bus.i_q_x, bus.i_q_y) ?
                    map_reg[cell_idx(bus.i_q_x, bus.i_q_y)] : 1'b1;
    end
  end

  assign bus.o_wr_ready  = (state_reg == ST_RUN) && !bus.i_busy && !bus.i_reload;
  assign wr_fire         = bus.i_wr_valid && bus.o_wr_ready;
  assign bus.o_is_map    = is_map_reg;
  assign bus.o_q_wall    = q_wall_reg;
  assign bus.o_init_done = init_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      init_x_reg    <= '0;
      init_y_reg    <= '0;
      map_reg       <= '0;
      is_map_reg    <= 1'b0;
      q_wall_reg    <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      is_map_reg <= is_map_next;
      q_wall_reg <= q_wall_next;
      if (bus.i_reload) begin
        state_reg     <= ST_INIT;
        cnt_reg       <= '0;
        init_x_reg    <= '0;
        init_y_reg    <= '0;
        init_done_reg <= 1'b0;
      end else if (state_reg == ST_INIT) begin
        map_reg[cnt_reg] <= default_bit;
        cnt_reg          <= cnt_reg + 1'b1;
        if (init_x_reg == X_LAST) begin
          init_x_reg <= '0;
          init_y_reg <= init_y_reg + 1'b1;
        end else begin
          init_x_reg <= init_x_reg + 1'b1;
        end
        if (cnt_reg == LAST_IDX) begin
          state_reg     <= ST_RUN;
          init_done_reg <= 1'b1;
        end
      end else if (wr_fire && in_map(bus.i_wr_x, bus.i_wr_y)) begin
        // Reads above sample map_reg before this update: read-before-write.
        map_reg[cell_idx(bus.i_wr_x, bus.i_wr_y)] <= bus.i_wr_wall;
      end
    end
  end
endmodule

// File: tb/tb_map_server.sv
// Directed checks of map_server: load timing, default map, writes, stalls,
// read-before-write, reload and asynchronous reset.
module tb_map_server;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  map_server_if #(.COORD_W(6)) bus ();

  map_server #(.MAP_W(40), .MAP_H(30), .COORD_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic vga(input int x, input int y, input logic exp);
    bus.i_x_pos = 6'(x);
    bus.i_y_pos = 6'(y);
    tick();
    chk($sformatf("vga(%0d,%0d)", x, y), bus.o_is_map, exp);
  endtask

  task automatic qry(input int x, input int y, input logic exp);
    bus.i_q_x = 6'(x);
    bus.i_q_y = 6'(y);
    tick();
    chk($sformatf("qry(%0d,%0d)", x, y), bus.o_q_wall, exp);
  endtask

  task automatic wr_set(input int x, input int y, input logic w);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_x     = 6'(x);
    bus.i_wr_y     = 6'(y);
    bus.i_wr_wall  = w;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_is_map"}, bus.o_is_map, 1'b0);
    chk({tag, "_q_wall"}, bus.o_q_wall, 1'b0);
    chk({tag, "_wr_ready"}, bus.o_wr_ready, 1'b0);
    chk({tag, "_init_done"}, bus.o_init_done, 1'b0);
  endtask

  // Counts edges from the first posedge after a reset release or reload edge.
  task automatic wait_load(input string tag, input int already);
    repeat (1199 - already) tick();
    chk({tag, "_done_1199"}, bus.o_init_done, 1'b0);
    chk({tag, "_read_in_init"}, bus.o_is_map, 1'b0);
    tick();
    chk({tag, "_done_1200"}, bus.o_init_done, 1'b1);
  endtask

  initial begin
    bus.i_reload = 1'b0; bus.i_busy = 1'b0;
    bus.i_x_pos = '0; bus.i_y_pos = '0; bus.i_q_x = '0; bus.i_q_y = '0;
    bus.i_wr_valid = 1'b0; bus.i_wr_x = '0; bus.i_wr_y = '0; bus.i_wr_wall = 1'b0;

    #30;
    chk_cleared("reset");
    #15 rst_n = 1'b1;
    wait_load("load0", 0);

    vga(0, 0, 1'b1);
    vga(4, 3, 1'b1);
    vga(5, 3, 1'b0);
    vga(39, 29, 1'b1);
    vga(40, 0, 1'b1);
    vga(63, 63, 1'b1);
    vga(20, 15, 1'b1);
    vga(12, 10, 1'b0);
    vga(1, 1, 1'b0);
    qry(36, 27, 1'b1);
    qry(0, 30, 1'b1);
    qry(38, 28, 1'b0);

    // Destroy the pillar at (4,3).
    wr_set(4, 3, 1'b0);
    #1 chk("wr_ready_run", bus.o_wr_ready, 1'b1);
    tick();
    bus.i_wr_valid = 1'b0;
    qry(4, 3, 1'b0);

    // Stall under i_busy, then commit when it drops.
    bus.i_busy = 1'b1;
    wr_set(5, 3, 1'b1);
    #1 chk("wr_ready_busy", bus.o_wr_ready, 1'b0);
    qry(5, 3, 1'b0);
    qry(5, 3, 1'b0);
    bus.i_busy = 1'b0;
    #1 chk("wr_ready_unbusy", bus.o_wr_ready, 1'b1);
    qry(5, 3, 1'b0);
    bus.i_wr_valid = 1'b0;
    qry(5, 3, 1'b1);

    // Same-cycle write and read of (10,10).
    wr_set(10, 10, 1'b1);
    qry(10, 10, 1'b0);
    bus.i_wr_valid = 1'b0;
    qry(10, 10, 1'b1);

    // Off-map write must not alias onto (0,6) = index 240.
    wr_set(40, 5, 1'b0);
    #1 chk("wr_ready_oob", bus.o_wr_ready, 1'b1);
    tick();
    bus.i_wr_valid = 1'b0;
    qry(0, 6, 1'b1);
    qry(39, 5, 1'b1);

    // Reload with a write in the same cycle: the write is dropped.
    bus.i_reload = 1'b1;
    wr_set(1, 1, 1'b1);
    #1 chk("wr_ready_reload", bus.o_wr_ready, 1'b0);
    tick();
    bus.i_reload = 1'b0;
    bus.i_wr_valid = 1'b0;
    chk("reload_done_low", bus.o_init_done, 1'b0);
    vga(10, 10, 1'b0);
    wait_load("reload", 1);
    vga(4, 3, 1'b1);
    vga(5, 3, 1'b0);
    qry(10, 10, 1'b0);
    qry(1, 1, 1'b0);

    // Edit, reload, then reset at counter 600.
    wr_set(1, 1, 1'b1);
    tick();
    bus.i_wr_valid = 1'b0;
    qry(1, 1, 1'b1);
    bus.i_reload = 1'b1;
    tick();
    bus.i_reload = 1'b0;
    repeat (600) tick();
    #5 rst_n = 1'b0;
    #1 chk_cleared("rst_init600");
    #5 rst_n = 1'b1;
    wait_load("load1", 0);
    qry(1, 1, 1'b0);
    vga(4, 27, 1'b1);
    vga(28, 21, 1'b1);
    vga(28, 22, 1'b0);

    // Asynchronous clear while RUN outputs are high.
    bus.i_x_pos = 6'd0; bus.i_y_pos = 6'd0;
    bus.i_q_x = 6'd0; bus.i_q_y = 6'd0;
    tick();
    chk("run_is_map_hi", bus.o_is_map, 1'b1);
    #5 rst_n = 1'b0;
    #1 chk_cleared("rst_run");
    #5 rst_n = 1'b1;
    wait_load("load2", 0);
    vga(0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
